// File: rtl/input_request_controller_if.sv
// CPU-side handshake bundle for the IN-instruction input controller.
// master: the CPU/board side driving the request, switches and button.
// slave : the controller.
interface input_request_controller_if #(
  parameter int SW_W   = 16,
  parameter int DATA_W = 32
) ();
  logic              in_req;
  logic [SW_W-1:0]   sw_in;
  logic              btn_db;
  logic [DATA_W-1:0] data_out;
  logic              in_ack;
  logic              in_timeout;
  logic              stall;
  logic              waiting_led;

  modport master (
    output in_req, sw_in, btn_db,
    input  data_out, in_ack, in_timeout, stall, waiting_led
  );

  modport slave (
    input  in_req, sw_in, btn_db,
    output data_out, in_ack, in_timeout, stall, waiting_led
  );
endinterface

// File: rtl/input_request_controller.sv
// Sequences user input for the IN instruction: stalls the CPU on request,
// waits for a fresh press of the enter button, latches the (extended) switch
// bank and releases the CPU with a one-cycle ack. An optional timeout forces
// completion with a zero value flagged by in_timeout.
module input_request_controller #(
  parameter int          SW_W           = 16,
  parameter int          DATA_W         = 32,
  parameter bit          SIGN_EXT       = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input_request_controller_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT_PRESS, ACK} state_t;

  // Last timer value before forced completion; wraps harmlessly when disabled.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t             state, state_nxt;
  logic               btn_prev;
  logic [31:0]        timer;
  logic               rise;
  logic               to_hit;
  logic               capture;
  logic               force_to;
  logic [DATA_W-1:0]  sw_ext;

  assign rise   = bus.btn_db & ~btn_prev;
  assign to_hit = TO_EN && (timer == TO_LAST);
  assign sw_ext = SIGN_EXT ? DATA_W'($signed(bus.sw_in)) : DATA_W'(bus.sw_in);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: a dropped request (CPU flush) aborts before anything else;
  // a press beats a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (bus.in_req) state_nxt = ARM;
      ARM: begin
        if (!bus.in_req)     state_nxt = IDLE;
        else if (to_hit)     state_nxt = ACK;
        else if (!bus.btn_db) state_nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!bus.in_req)         state_nxt = IDLE;
        else if (rise || to_hit) state_nxt = ACK;
      end
      ACK:        state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Combinational outputs and completion qualifiers.
  always_comb begin
    bus.stall       = 1'b0;
    bus.waiting_led = 1'b0;
    capture         = 1'b0;
    force_to        = 1'b0;
    case (state)
      IDLE: bus.stall = bus.in_req;
      ARM: begin
        bus.stall       = 1'b1;
        bus.waiting_led = 1'b1;
        force_to        = bus.in_req & to_hit;
      end
      WAIT_PRESS: begin
        bus.stall       = 1'b1;
        bus.waiting_led = 1'b1;
        capture         = bus.in_req & rise;
        force_to        = bus.in_req & ~rise & to_hit;
      end
      default: ;
    endcase
  end

  // Button history for edge detection; timer runs only while prompting
  // and saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev <= 1'b0;
      timer    <= '0;
    end else begin
      btn_prev <= bus.btn_db;
      if (TO_EN && (state == ARM || state == WAIT_PRESS)) begin
        if (timer != '1) timer <= timer + 32'd1;
      end else begin
        timer <= '0;
      end
    end
  end

  // Registered handshake outputs: data held until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.data_out   <= '0;
      bus.in_ack     <= 1'b0;
      bus.in_timeout <= 1'b0;
    end else begin
      bus.in_ack     <= capture | force_to;
      bus.in_timeout <= force_to;
      if (capture)       bus.data_out <= sw_ext;
      else if (force_to) bus.data_out <= '0;
    end
  end

endmodule

// File: tb/tb_input_request_controller.sv
// Directed bench: u0 = zero-extend, no timeout; u1 = sign-extend, 10-cycle timeout.
module tb_input_request_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  input_request_controller_if #(.SW_W(16), .DATA_W(32)) b0 ();
  input_request_controller_if #(.SW_W(16), .DATA_W(32)) b1 ();

  input_request_controller #(.SW_W(16), .DATA_W(32), .SIGN_EXT(1'b0), .TIMEOUT_CYCLES(0))
    u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  input_request_controller #(.SW_W(16), .DATA_W(32), .SIGN_EXT(1'b1), .TIMEOUT_CYCLES(10))
    u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    b0.in_req = 0; b0.btn_db = 0; b0.sw_in = '0;
    b1.in_req = 0; b1.btn_db = 0; b1.sw_in = '0;

    // Reset state
    #2;
    chk("rst_data", b0.data_out, 32'h0);
    chk("rst_ack", {31'b0, b0.in_ack}, 32'h0);
    chk("rst_to", {31'b0, b0.in_timeout}, 32'h0);
    chk("rst_stall", {31'b0, b0.stall}, 32'h0);
    chk("rst_led", {31'b0, b0.waiting_led}, 32'h0);
    tick();
    reset = 0;

    // 1: basic request, minimum latency
    b0.sw_in = 16'h00A5; b0.in_req = 1;
    #1 chk("t1_stall_req", {31'b0, b0.stall}, 32'h1);
    chk("t1_led_idle", {31'b0, b0.waiting_led}, 32'h0);
    tick();                                   // ARM
    chk("t1_led_arm", {31'b0, b0.waiting_led}, 32'h1);
    chk("t1_ack_arm", {31'b0, b0.in_ack}, 32'h0);
    tick();                                   // WAIT_PRESS
    b0.btn_db = 1;
    tick();                                   // ACK
    chk("t1_ack", {31'b0, b0.in_ack}, 32'h1);
    chk("t1_data", b0.data_out, 32'h000000A5);
    chk("t1_to", {31'b0, b0.in_timeout}, 32'h0);
    chk("t1_stall_ack", {31'b0, b0.stall}, 32'h0);
    b0.in_req = 0; b0.btn_db = 0;
    tick();
    chk("t1_ack_off", {31'b0, b0.in_ack}, 32'h0);
    chk("t1_hold", b0.data_out, 32'h000000A5);

    // 2: button held at request time must be released and re-pressed
    b0.btn_db = 1; b0.sw_in = 16'h1234; b0.in_req = 1;
    tick(); tick(); tick();
    chk("t2_no_ack_held", {31'b0, b0.in_ack}, 32'h0);
    chk("t2_led_held", {31'b0, b0.waiting_led}, 32'h1);
    b0.btn_db = 0;
    tick();                                   // WAIT_PRESS
    chk("t2_no_ack_rel", {31'b0, b0.in_ack}, 32'h0);
    b0.sw_in = 16'h0055; b0.btn_db = 1;
    tick();
    chk("t2_ack", {31'b0, b0.in_ack}, 32'h1);
    chk("t2_data", b0.data_out, 32'h00000055);
    b0.in_req = 0; b0.btn_db = 0;
    tick();

    // 5: back-to-back requests, second needs a fresh press
    b0.sw_in = 16'd3; b0.in_req = 1;
    tick(); tick();
    b0.btn_db = 1;
    tick();
    chk("t5_ack1", {31'b0, b0.in_ack}, 32'h1);
    chk("t5_data1", b0.data_out, 32'd3);
    chk("t5_stall_ack", {31'b0, b0.stall}, 32'h0);
    b0.sw_in = 16'd7;                         // in_req and button stay high
    tick();                                   // IDLE, new request
    chk("t5_gap_ack", {31'b0, b0.in_ack}, 32'h0);
    chk("t5_gap_stall", {31'b0, b0.stall}, 32'h1);
    tick(); tick();                           // ARM, held button
    chk("t5_no_ack_held", {31'b0, b0.in_ack}, 32'h0);
    chk("t5_data_kept", b0.data_out, 32'd3);
    b0.btn_db = 0;
    tick();
    b0.btn_db = 1;
    tick();
    chk("t5_ack2", {31'b0, b0.in_ack}, 32'h1);
    chk("t5_data2", b0.data_out, 32'd7);
    b0.in_req = 0; b0.btn_db = 0;
    tick();

    // Abort: request dropped in WAIT_PRESS
    b0.sw_in = 16'h00EE; b0.in_req = 1;
    tick(); tick();
    b0.in_req = 0;
    #1 chk("ab_stall", {31'b0, b0.stall}, 32'h1);
    tick();
    chk("ab_ack", {31'b0, b0.in_ack}, 32'h0);
    chk("ab_data", b0.data_out, 32'd7);
    chk("ab_led", {31'b0, b0.waiting_led}, 32'h0);
    b0.btn_db = 1;
    tick();
    chk("ab_no_late_ack", {31'b0, b0.in_ack}, 32'h0);
    b0.btn_db = 0;
    tick();

    // 4: extension, both instances with the same switch value
    b0.sw_in = 16'h8001; b1.sw_in = 16'h8001;
    b0.in_req = 1; b1.in_req = 1;
    tick(); tick();
    b0.btn_db = 1; b1.btn_db = 1;
    tick();
    chk("t4_zext", b0.data_out, 32'h00008001);
    chk("t4_sext", b1.data_out, 32'hFFFF8001);
    chk("t4_sext_to", {31'b0, b1.in_timeout}, 32'h0);
    b0.in_req = 0; b1.in_req = 0; b0.btn_db = 0; b1.btn_db = 0;
    tick();

    // 3: timeout, ack exactly 10 cycles after ARM entry
    b1.sw_in = 16'h1234; b1.in_req = 1;
    tick();                                   // ARM entry edge
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("t3_no_ack_%0d", i), {31'b0, b1.in_ack}, 32'h0);
    end
    tick();
    chk("t3_ack", {31'b0, b1.in_ack}, 32'h1);
    chk("t3_to", {31'b0, b1.in_timeout}, 32'h1);
    chk("t3_data", b1.data_out, 32'h0);
    b1.in_req = 0;
    tick();
    chk("t3_to_off", {31'b0, b1.in_timeout}, 32'h0);
    chk("t3_ack_off", {31'b0, b1.in_ack}, 32'h0);

    // Press in the timeout cycle: capture wins
    b1.sw_in = 16'h0042; b1.in_req = 1;
    tick();                                   // ARM entry
    for (int i = 1; i <= 9; i++) tick();
    b1.btn_db = 1;
    tick();
    chk("tie_ack", {31'b0, b1.in_ack}, 32'h1);
    chk("tie_to", {31'b0, b1.in_timeout}, 32'h0);
    chk("tie_data", b1.data_out, 32'h00000042);
    b1.in_req = 0; b1.btn_db = 0;
    tick();

    // 6: reset while in WAIT_PRESS, then a normal request
    b0.sw_in = 16'h0099; b0.in_req = 1;
    tick(); tick();
    reset = 1;
    #1;
    chk("t6_data", b0.data_out, 32'h0);
    chk("t6_ack", {31'b0, b0.in_ack}, 32'h0);
    chk("t6_led", {31'b0, b0.waiting_led}, 32'h0);
    chk("t6_stall_req", {31'b0, b0.stall}, 32'h1);
    b0.in_req = 0;
    #1 chk("t6_stall_idle", {31'b0, b0.stall}, 32'h0);
    tick();
    reset = 0;
    b0.sw_in = 16'h0011; b0.in_req = 1;
    tick(); tick();
    b0.btn_db = 1;
    tick();
    chk("t6_ack_after", {31'b0, b0.in_ack}, 32'h1);
    chk("t6_data_after", b0.data_out, 32'h00000011);
    b0.in_req = 0; b0.btn_db = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end
endmodule
